// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Both the top level and the kill FIFO import this package.
package regfile_arb_pkg;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_EXC  = 2'd2,
        SRC_MDU  = 2'd3
    } src_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          live;
    } wr_req_t;

    // Destination match that never fires on the hard-wired zero register.
    function automatic logic addr_hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a == b) && (a != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writer, decode-query and register-file signals around the write arbiter.
// The core side uses modport master; the arbiter uses modport slave.
interface regfile_write_arbiter_if;
    import regfile_arb_pkg::*;

    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          exc_we;
    logic [AW-1:0] exc_addr;
    logic [DW-1:0] exc_data;
    logic          exc_busy;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic [AW-1:0] q_addr1;
    logic [AW-1:0] q_addr2;
    logic          q_busy1;
    logic          q_busy2;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          stall_req;
    logic [1:0]    err;

    modport master (
        output wb_we, wb_addr, wb_data,
        output exc_we, exc_addr, exc_data,
        output mdu_valid, mdu_addr, mdu_data,
        output q_addr1, q_addr2,
        input  exc_busy, mdu_ready, q_busy1, q_busy2,
        input  rf_we, rf_addr, rf_data, stall_req, err
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  exc_we, exc_addr, exc_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  q_addr1, q_addr2,
        output exc_busy, mdu_ready, q_busy1, q_busy2,
        output rf_we, rf_addr, rf_data, stall_req, err
    );

endinterface

// File: rtl/regfile_write_arbiter_kill_fifo.sv
// In-order FIFO of buffered MDU writes. A WB write can kill matching entries in place;
// dead entries stay in order and are discarded by the consumer when they reach the head.
module kill_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wr_req_t          push_req,
    input  logic             pop,
    input  logic             kill_en,
    input  logic [AW-1:0]    kill_addr,
    input  logic [AW-1:0]    q_addr1,
    input  logic [AW-1:0]    q_addr2,
    output wr_req_t          head,
    output logic             empty,
    output logic             full,
    output logic             any_live,
    output logic [DEPTH-1:0] hit1,
    output logic [DEPTH-1:0] hit2
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wr_req_t        mem_r [DEPTH];
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == CW'(0));
    assign full  = (count_r == CW'(DEPTH));

    // Storage, pointers and occupancy; live is cleared on pop so free slots never look busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= PW'(0);
            wr_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr_r == PW'(i))) begin
                    mem_r[i] <= push_req;
                end else if ((pop && (rd_ptr_r == PW'(i))) ||
                             (kill_en && (mem_r[i].addr == kill_addr))) begin
                    mem_r[i].live <= 1'b0;
                end
            end
        end
    end

    // Per-entry decode-query compares and the any-live summary for the age counter.
    always_comb begin
        hit1     = '0;
        hit2     = '0;
        any_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i]  = mem_r[i].live && addr_hit(mem_r[i].addr, q_addr1);
            hit2[i]  = mem_r[i].live && addr_hit(mem_r[i].addr, q_addr2);
            any_live = any_live | mem_r[i].live;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared by WB (always wins), a buffered exception link
// write and buffered MDU results, with WAW kill, decode busy flags and starvation stall.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    localparam int AGEW = $clog2(STARVE_LIMIT + 1);

    wr_req_t          exc_slot_r;
    logic [AGEW-1:0]  age_r;
    logic [1:0]       err_r;
    src_t             src_s;
    wr_req_t          mdu_req_s;
    wr_req_t          head_s;
    logic             empty_s;
    logic             full_s;
    logic             fifo_live_s;
    logic [DEPTH-1:0] hit1_s;
    logic [DEPTH-1:0] hit2_s;
    logic             wb_live_s;
    logic             mdu_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             exc_req_s;
    logic             exc_load_s;
    logic             stall_s;
    logic             drained_s;
    logic             buffered_s;

    // Writes to register 0 are treated as no write at all.
    assign wb_live_s   = !reset && bus.wb_we && (bus.wb_addr != ZERO_REG);
    assign mdu_ready_s = !reset && !full_s;
    assign push_s      = bus.mdu_valid && mdu_ready_s && (bus.mdu_addr != ZERO_REG);
    assign mdu_req_s   = '{addr: bus.mdu_addr, data: bus.mdu_data, live: 1'b1};
    assign pop_s       = !empty_s && ((src_s == SRC_MDU) || !head_s.live);
    assign exc_req_s   = bus.exc_we && (bus.exc_addr != ZERO_REG);
    assign exc_load_s  = exc_req_s && !exc_slot_r.live;
    assign stall_s     = (age_r == AGEW'(STARVE_LIMIT));
    assign drained_s   = (src_s == SRC_EXC) || (src_s == SRC_MDU);
    assign buffered_s  = exc_slot_r.live || fifo_live_s;

    kill_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_req  (mdu_req_s),
        .pop       (pop_s),
        .kill_en   (wb_live_s),
        .kill_addr (bus.wb_addr),
        .q_addr1   (bus.q_addr1),
        .q_addr2   (bus.q_addr2),
        .head      (head_s),
        .empty     (empty_s),
        .full      (full_s),
        .any_live  (fifo_live_s),
        .hit1      (hit1_s),
        .hit2      (hit2_s)
    );

    // Fixed-priority grant: WB, then the exception slot, then a live FIFO head.
    always_comb begin
        src_s = SRC_NONE;
        if (reset) begin
            src_s = SRC_NONE;
        end else if (wb_live_s) begin
            src_s = SRC_WB;
        end else if (exc_slot_r.live) begin
            src_s = SRC_EXC;
        end else if (!empty_s && head_s.live) begin
            src_s = SRC_MDU;
        end else begin
            src_s = SRC_NONE;
        end
    end

    // Zero-latency write-port mux; idle cycles drive an all-zero port.
    always_comb begin
        bus.rf_we   = 1'b0;
        bus.rf_addr = ZERO_REG;
        bus.rf_data = 32'd0;
        case (src_s)
            SRC_WB: begin
                bus.rf_we   = 1'b1;
                bus.rf_addr = bus.wb_addr;
                bus.rf_data = bus.wb_data;
            end
            SRC_EXC: begin
                bus.rf_we   = 1'b1;
                bus.rf_addr = exc_slot_r.addr;
                bus.rf_data = exc_slot_r.data;
            end
            SRC_MDU: begin
                bus.rf_we   = 1'b1;
                bus.rf_addr = head_s.addr;
                bus.rf_data = head_s.data;
            end
            default: begin
                bus.rf_we   = 1'b0;
                bus.rf_addr = ZERO_REG;
                bus.rf_data = 32'd0;
            end
        endcase
    end

    // Exception slot: loads only when empty, leaves when granted or killed by a WB WAW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_slot_r <= '0;
        end else if (exc_load_s) begin
            exc_slot_r <= '{addr: bus.exc_addr, data: bus.exc_data, live: 1'b1};
        end else if ((src_s == SRC_EXC) ||
                     (wb_live_s && (exc_slot_r.addr == bus.wb_addr))) begin
            exc_slot_r.live <= 1'b0;
        end
    end

    // Starvation age (saturating) and sticky protocol-violation flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_r <= AGEW'(0);
            err_r <= 2'b00;
        end else begin
            if (drained_s || !buffered_s) begin
                age_r <= AGEW'(0);
            end else if (!stall_s) begin
                age_r <= age_r + AGEW'(1);
            end
            err_r[0] <= err_r[0] | (exc_req_s && exc_slot_r.live);
            err_r[1] <= err_r[1] | (bus.wb_we && stall_s);
        end
    end

    assign bus.exc_busy  = exc_slot_r.live;
    assign bus.mdu_ready = mdu_ready_s;
    assign bus.q_busy1   = (|hit1_s) || (exc_slot_r.live && addr_hit(exc_slot_r.addr, bus.q_addr1));
    assign bus.q_busy2   = (|hit2_s) || (exc_slot_r.live && addr_hit(exc_slot_r.addr, bus.q_addr2));
    assign bus.stall_req = stall_s;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: every register-file write the stimulus implies is queued as it is driven
// and matched in order when the arbiter asserts rf_we; flags are compared in between.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_wr_t;

    logic    clk = 1'b0;
    logic    reset;
    int      n_checks = 0;
    int      n_errors = 0;
    exp_wr_t exp_q[$];

    always #5 clk = ~clk;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back('{a, d});
    endtask

    task automatic idle_in();
        bus.wb_we     = 1'b0;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'd0;
        bus.exc_we    = 1'b0;
        bus.exc_addr  = 5'd0;
        bus.exc_data  = 32'd0;
        bus.mdu_valid = 1'b0;
        bus.mdu_addr  = 5'd0;
        bus.mdu_data  = 32'd0;
    endtask

    task automatic drive_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_we   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        if (a != 5'd0) expect_wr(a, d);
    endtask

    task automatic drive_mdu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.mdu_valid = 1'b1;
        bus.mdu_addr  = a;
        bus.mdu_data  = d;
    endtask

    task automatic drive_exc(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.exc_we   = 1'b1;
        bus.exc_addr = a;
        bus.exc_data = d;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic settle();
        #2;
    endtask

    // Write monitor: every rf_we must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_wr_t e;
        if (reset === 1'b0 && bus.rf_we === 1'b1) begin
            check_val("wr_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("rf_addr", 64'(bus.rf_addr), 64'(e.addr));
                check_val("rf_data", 64'(bus.rf_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        bus.q_addr1 = 5'd0;
        bus.q_addr2 = 5'd0;
        idle_in();
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'h1;
        #3;
        check_val("rst_rf_we", 64'(bus.rf_we), 64'd0);
        check_val("rst_rf_addr", 64'(bus.rf_addr), 64'd0);
        check_val("rst_mdu_ready", 64'(bus.mdu_ready), 64'd0);
        check_val("rst_exc_busy", 64'(bus.exc_busy), 64'd0);
        check_val("rst_stall", 64'(bus.stall_req), 64'd0);
        check_val("rst_err", 64'(bus.err), 64'd0);
        next_cyc();
        next_cyc();
        reset = 1'b0;
        settle();
        check_val("post_rst_ready", 64'(bus.mdu_ready), 64'd1);
        check_val("post_rst_we", 64'(bus.rf_we), 64'd0);

        // WB only, including the register-0 case
        next_cyc(); drive_wb(5'd5, 32'hA5); settle();
        check_val("t1_rf_we", 64'(bus.rf_we), 64'd1);
        check_val("t1_rf_addr", 64'(bus.rf_addr), 64'd5);
        next_cyc(); drive_wb(5'd0, 32'h1); settle();
        check_val("t1_zero_we", 64'(bus.rf_we), 64'd0);

        // MDU result waits behind three WB cycles
        bus.q_addr1 = 5'd9;
        next_cyc(); drive_wb(5'd1, 32'h11); drive_mdu(5'd9, 32'h1234); settle();
        check_val("t2_ready", 64'(bus.mdu_ready), 64'd1);
        check_val("t2_busy_pre", 64'(bus.q_busy1), 64'd0);
        next_cyc(); drive_wb(5'd2, 32'h22); settle();
        check_val("t2_busy_a", 64'(bus.q_busy1), 64'd1);
        next_cyc(); drive_wb(5'd3, 32'h33); settle();
        check_val("t2_busy_b", 64'(bus.q_busy1), 64'd1);
        next_cyc(); expect_wr(5'd9, 32'h1234); settle();
        check_val("t2_mdu_we", 64'(bus.rf_we), 64'd1);
        check_val("t2_busy_c", 64'(bus.q_busy1), 64'd1);
        next_cyc(); settle();
        check_val("t2_busy_done", 64'(bus.q_busy1), 64'd0);
        check_val("t2_idle_we", 64'(bus.rf_we), 64'd0);

        // EXC before MDU; second exc_we while busy is dropped and flagged
        next_cyc(); drive_wb(5'd4, 32'h44); drive_exc(5'd26, 32'h80); drive_mdu(5'd10, 32'h55); settle();
        check_val("t3_busy_pre", 64'(bus.exc_busy), 64'd0);
        next_cyc(); expect_wr(5'd26, 32'h80); drive_exc(5'd27, 32'h99); settle();
        check_val("t3_exc_busy", 64'(bus.exc_busy), 64'd1);
        check_val("t3_exc_addr", 64'(bus.rf_addr), 64'd26);
        next_cyc(); expect_wr(5'd10, 32'h55); settle();
        check_val("t3_mdu_addr", 64'(bus.rf_addr), 64'd10);
        check_val("t3_busy_clr", 64'(bus.exc_busy), 64'd0);
        check_val("t3_err", 64'(bus.err), 64'd1);
        next_cyc(); settle();
        check_val("t3_idle_we", 64'(bus.rf_we), 64'd0);

        // WAW kill of a buffered MDU entry
        bus.q_addr2 = 5'd7;
        next_cyc(); drive_wb(5'd1, 32'h1); drive_mdu(5'd7, 32'h77); settle();
        next_cyc(); drive_wb(5'd7, 32'h777); settle();
        check_val("t4_busy_pre", 64'(bus.q_busy2), 64'd1);
        check_val("t4_wb_data", 64'(bus.rf_data), 64'h777);
        next_cyc(); settle();
        check_val("t4_busy_kill", 64'(bus.q_busy2), 64'd0);
        check_val("t4_no_we_a", 64'(bus.rf_we), 64'd0);
        next_cyc(); settle();
        check_val("t4_no_we_b", 64'(bus.rf_we), 64'd0);

        // Starvation: WB held with a buffered MDU entry
        next_cyc(); drive_wb(5'd1, 32'h100); drive_mdu(5'd12, 32'hC0C0); settle();
        for (int k = 1; k <= 10; k++) begin
            next_cyc(); drive_wb(5'd2, 32'h200 + 32'(k)); settle();
            check_val($sformatf("t5_stall_%0d", k), 64'(bus.stall_req), 64'(k >= 9));
        end
        next_cyc(); expect_wr(5'd12, 32'hC0C0); settle();
        check_val("t5_grant_addr", 64'(bus.rf_addr), 64'd12);
        check_val("t5_stall_hold", 64'(bus.stall_req), 64'd1);
        next_cyc(); settle();
        check_val("t5_stall_clr", 64'(bus.stall_req), 64'd0);
        check_val("t5_err", 64'(bus.err), 64'd3);

        // Reset with FIFO full and EXC pending
        bus.q_addr1 = 5'd13;
        next_cyc(); drive_wb(5'd1, 32'h1); drive_mdu(5'd13, 32'hD); drive_exc(5'd26, 32'h1); settle();
        next_cyc(); drive_wb(5'd2, 32'h2); drive_mdu(5'd14, 32'hE); settle();
        check_val("t6_ready_one", 64'(bus.mdu_ready), 64'd1);
        next_cyc(); drive_wb(5'd3, 32'h3); settle();
        check_val("t6_full", 64'(bus.mdu_ready), 64'd0);
        check_val("t6_exc_busy", 64'(bus.exc_busy), 64'd1);
        check_val("t6_q_busy", 64'(bus.q_busy1), 64'd1);
        next_cyc(); reset = 1'b1; bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h5; #1;
        check_val("t6_rst_we", 64'(bus.rf_we), 64'd0);
        check_val("t6_rst_addr", 64'(bus.rf_addr), 64'd0);
        check_val("t6_rst_data", 64'(bus.rf_data), 64'd0);
        check_val("t6_rst_exc", 64'(bus.exc_busy), 64'd0);
        check_val("t6_rst_ready", 64'(bus.mdu_ready), 64'd0);
        check_val("t6_rst_qbusy", 64'(bus.q_busy1), 64'd0);
        check_val("t6_rst_stall", 64'(bus.stall_req), 64'd0);
        check_val("t6_rst_err", 64'(bus.err), 64'd0);
        next_cyc();
        next_cyc(); reset = 1'b0; settle();
        check_val("t6_rel_ready", 64'(bus.mdu_ready), 64'd1);
        check_val("t6_rel_exc", 64'(bus.exc_busy), 64'd0);
        check_val("t6_rel_qbusy", 64'(bus.q_busy1), 64'd0);
        for (int k = 0; k < 3; k++) begin
            next_cyc(); settle();
            check_val($sformatf("t6_no_stale_%0d", k), 64'(bus.rf_we), 64'd0);
        end

        next_cyc();
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
